tcdm_block_initiator: RTL and testbench
=======================================

// Module: tcdm_block_initiator
// PURPOSE
//  Initiator (master) on the cluster XBAR_TCDM_BUS protocol; counterpart of the BRAM-backed TCDM banks.
//  Turns one block command (base address, word count, direction) into word transactions on the bus.
//  Respects gnt arbitration and buffers read responses in a credit-controlled FIFO.
//  Feeds the result to a valid/ready stream. Sits between accelerator/DMA logic and a TCDM slave port.
// PARAMETERS
//  LEN_WIDTH   16  width of command word count (max 2^LEN_WIDTH-1 words per command)
//  FIFO_DEPTH  4   read-response FIFO entries, power of two, >=2; bounds outstanding reads
// PORTS
//  clk_i          in   1          clock
//  rst_ni         in   1          asynchronous active-low reset
//  cmd_valid_i    in   1          command valid
//  cmd_ready_o    out  1          command accepted when valid&ready
//  cmd_addr_i     in   32         byte base address, word aligned (bits[1:0] ignored, forced 0)
//  cmd_len_i      in   LEN_WIDTH  number of 32-bit words
//  cmd_we_i       in   1          1=write block, 0=read block
//  wdata_valid_i  in   1          write data stream valid
//  wdata_ready_o  out  1          write word consumed (equals bus write grant)
//  wdata_i        in   32         write data
//  rdata_valid_o  out  1          read data stream valid (FIFO not empty)
//  rdata_ready_i  in   1          read data stream ready
//  rdata_o        out  32         read data (FIFO head)
//  busy_o         out  1          command in progress
//  done_o         out  1          one-cycle pulse: last response of command received
//  tcdm_master    XBAR_TCDM_BUS.Master  req/add/wen/wdata/be out; gnt/r_valid/r_rdata/r_opc in
// BEHAVIOUR
//  Reset (async, rst_ni=0): state IDLE; counters, FIFO, and in-flight count cleared.
//   Outputs during reset: req=0, add=0, wen=1, wdata=0, be=0; cmd_ready_o=0; wdata_ready_o=0;
//   rdata_valid_o=0; rdata_o=0; busy_o=0; done_o=0.
//  Reset mid-command aborts the command: queued read data is discarded, pending bus request is dropped.
//  FSM states: IDLE, ISSUE, DRAIN.
//  IDLE: cmd_ready_o=1. On accept, latch addr/len/we.
//   If len=0: done_o=1 in the next cycle, stay in IDLE, no bus activity.
//   Otherwise go to ISSUE; busy_o=1 from the cycle after accept until the cycle done_o is high (inclusive).
//  ISSUE, bus-side fields:
//   add = base + 4*issued, 32-bit wrap at 2^32; be=4'hF; wen=~we.
//  ISSUE, write command (we=1): req = wdata_valid_i. wdata = wdata_i. wdata_ready_o = req & gnt.
//  ISSUE, read command (we=0): req = (in_flight + fifo_count) < FIFO_DEPTH.
//   When the bus is stalled (req & ~gnt), no response FIFO space may be lost.
//  Bus rule: once req=1, req/add/wen/wdata/be stay stable until gnt=1.
//   Upstream must hold wdata_valid_i until wdata_ready_o.
//  Handshake: req&gnt increments issued and in_flight.
//   When issued reaches len, go to DRAIN with req=0 from the next cycle.
//  Responses (any state):
//   r_valid decrements in_flight and increments received.
//   Read command: push r_rdata into the FIFO. Write command: discard the response.
//   The slave returns r_valid exactly one cycle after grant; the design must still work at any latency >=1.
//  DRAIN: when received==len, done_o=1 for one cycle and return to IDLE.
//   A grant and the final response in the same cycle end in ISSUE->DRAIN->IDLE normally.
//  Simultaneous FIFO push and pop: count unchanged. Pop when empty: ignored.
//   Push when full: cannot happen by credit (sim assertion).
//  r_valid with in_flight=0: ignored, counters unchanged, sim assertion fires.
//  New command is not accepted until IDLE. Read FIFO data may remain after done_o and drains normally.
//  Widths: issued/received are LEN_WIDTH bits; in_flight is $clog2(FIFO_DEPTH)+1 bits.
// STRUCTURE
//  Package tcdm_init_pkg: state_e {IDLE,ISSUE,DRAIN}, WORD_BYTES=4, BE_ALL=4'hF.
//  Sub-module tcdm_init_fifo: synchronous FIFO, 32-bit wide x FIFO_DEPTH.
//   Async active-low reset; push/pop/full/empty/count; first-word fall-through on rdata_o.
//  Top level holds the FSM, counters, and credit logic.
// TESTING
//  Slave model: gnt always 1, r_valid one cycle after grant.
//  1 Read, gnt=1, addr=0x100, len=4, rdata_ready_i=1 ->
//    add=0x100,0x104,0x108,0x10C on 4 consecutive cycles;
//    4 words out in order; done_o 1 cycle after the last r_valid.
//  2 Read len=8, FIFO_DEPTH=4, rdata_ready_i=0 ->
//    exactly 4 grants, then req=0; raising ready resumes issue; all 8 words out in order.
//  3 Write addr=0x200, len=3, gnt toggling 1,0,1,0 ->
//    req/add/wdata held stable while gnt=0; wdata_ready_o only on grant;
//    slave memory holds the 3 words; done_o once.
//  4 Command len=0 -> cmd accepted, done_o next cycle, req never asserted, busy_o stays 0.
//  5 Read addr=0xFFFF_FFF8, len=4 -> add sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
//  6 rst_ni low mid-read (2 of 6 words issued) ->
//    outputs immediately at reset values, FIFO empty;
//    a new len=2 command after reset completes correctly.

Source files
------------

// File: rtl/tcdm_init_pkg.sv
// Shared types and constants for the TCDM block initiator.
// word_addr() gives the byte address of word idx of a block, wrapping at 2^32.
package tcdm_init_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam int unsigned WORD_BYTES = 4;
   localparam logic [3:0]  BE_ALL     = 4'hF;

   function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
      return base + idx * WORD_BYTES;
   endfunction

endpackage

// File: rtl/XBAR_TCDM_BUS.sv
// Cluster TCDM crossbar port.
// The initiator drives the request side; the bank returns gnt and responses.
interface XBAR_TCDM_BUS;
   logic        req;
   logic [31:0] add;
   logic        wen;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        gnt;
   logic        r_valid;
   logic [31:0] r_rdata;
   logic        r_opc;

   modport Master (output req, add, wen, wdata, be, input gnt, r_valid, r_rdata, r_opc);
   modport Slave  (input req, add, wen, wdata, be, output gnt, r_valid, r_rdata, r_opc);
endinterface

// File: rtl/tcdm_init_chk.sv
// Simulation checks for the initiator: response FIFO never overflows
// and the bus never returns a response nobody is waiting for.
module tcdm_init_chk (
   input logic clk_i,
   input logic rst_ni,
   input logic push_i,
   input logic full_i,
   input logic r_valid_i,
   input logic in_flight_zero_i
);
   a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_i));
   a_no_stray_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni) !(r_valid_i && in_flight_zero_i));
endmodule

// File: rtl/tcdm_init_fifo.sv
// Read-response FIFO, 32 bits x DEPTH, first-word fall-through.
// The head reads as zero while empty; push when full and pop when empty are ignored.
module tcdm_init_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   push_i,
   input  logic [31:0]            wdata_i,
   input  logic                   pop_i,
   output logic [31:0]            rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [31:0]   mem_r [DEPTH];
   logic [AW-1:0] wptr_r;
   logic [AW-1:0] rptr_r;
   logic [AW:0]   count_r;
   logic          do_push_s;
   logic          do_pop_s;

   assign full_o    = (count_r == FULL_CNT);
   assign empty_o   = (count_r == '0);
   assign do_push_s = push_i & ~full_o;
   assign do_pop_s  = pop_i & ~empty_o;
   assign count_o   = count_r;
   assign rdata_o   = empty_o ? 32'h0000_0000 : mem_r[rptr_r];

   // Storage array; contents behind the pointers are don't-care after reset
   always_ff @(posedge clk_i) begin
      if (do_push_s) begin
         mem_r[wptr_r] <= wdata_i;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         count_r <= '0;
      end else begin
         if (do_push_s) wptr_r <= wptr_r + AW'(1);
         if (do_pop_s)  rptr_r <= rptr_r + AW'(1);
         count_r <= count_r + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
      end
   end

endmodule

// File: rtl/tcdm_block_initiator.sv
// TCDM bus initiator: expands one block command into word transactions.
// Reads are credit-limited so every outstanding request has a FIFO slot.
module tcdm_block_initiator
   import tcdm_init_pkg::*;
#(
   parameter int unsigned LEN_WIDTH  = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 cmd_valid_i,
   output logic                 cmd_ready_o,
   input  logic [31:0]          cmd_addr_i,
   input  logic [LEN_WIDTH-1:0] cmd_len_i,
   input  logic                 cmd_we_i,
   input  logic                 wdata_valid_i,
   output logic                 wdata_ready_o,
   input  logic [31:0]          wdata_i,
   output logic                 rdata_valid_o,
   input  logic                 rdata_ready_i,
   output logic [31:0]          rdata_o,
   output logic                 busy_o,
   output logic                 done_o,
   XBAR_TCDM_BUS.Master         tcdm_master
);
   localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

   state_e               state_r, state_s;
   logic [31:0]          base_r;
   logic [LEN_WIDTH-1:0] len_r, issued_r, received_r, received_inc_s;
   logic                 we_r, alive_r, busy_r, done_r;
   logic [CW-1:0]        in_flight_r, fifo_count_s;
   logic [CW:0]          credit_s;
   logic                 req_s, wen_s, wdata_rdy_s, done_s, busy_s;
   logic [31:0]          add_s, wdata_s;
   logic [3:0]           be_s;
   logic                 cmd_hs_s, bus_hs_s, rsp_s, push_s, fifo_full_s, fifo_empty_s;
   logic                 unused_s;

   // alive_r keeps cmd_ready low until the first clock after reset release
   assign cmd_ready_o    = alive_r & (state_r == IDLE);
   assign cmd_hs_s       = cmd_valid_i & cmd_ready_o;
   assign bus_hs_s       = req_s & tcdm_master.gnt;
   assign rsp_s          = tcdm_master.r_valid & (in_flight_r != '0);
   assign push_s         = rsp_s & ~we_r;
   assign received_inc_s = received_r + LEN_WIDTH'(rsp_s);
   assign credit_s       = {1'b0, in_flight_r} + {1'b0, fifo_count_s};
   assign unused_s       = ^{cmd_addr_i[1:0], tcdm_master.r_opc};

   // Next state and bus-side outputs; every field idles at its reset value
   always_comb begin
      state_s     = state_r;
      req_s       = 1'b0;
      add_s       = 32'h0000_0000;
      wen_s       = 1'b1;
      wdata_s     = 32'h0000_0000;
      be_s        = 4'h0;
      wdata_rdy_s = 1'b0;
      done_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (cmd_hs_s && (cmd_len_i != '0)) begin
               state_s = ISSUE;
            end else if (cmd_hs_s) begin
               done_s = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            add_s = word_addr(base_r, 32'(issued_r));
            be_s  = BE_ALL;
            wen_s = ~we_r;
            if (we_r) begin
               req_s   = wdata_valid_i;
               wdata_s = wdata_i;
            end else begin
               req_s   = (credit_s < CREDITS);
            end
            wdata_rdy_s = req_s & tcdm_master.gnt & we_r;
            if (bus_hs_s && (issued_r == len_r - LEN_WIDTH'(1))) begin
               state_s = DRAIN;
            end else begin
               state_s = ISSUE;
            end
         end
         DRAIN: begin
            if (received_inc_s == len_r) begin
               state_s = IDLE;
               done_s  = 1'b1;
            end else begin
               state_s = DRAIN;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // busy covers the done cycle of a real command but not a zero-length one
   assign busy_s = (state_s != IDLE) | ((state_r == DRAIN) & done_s);

   // FSM, command latch and transaction counters
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r     <= IDLE;
         base_r      <= 32'h0000_0000;
         len_r       <= '0;
         we_r        <= 1'b0;
         issued_r    <= '0;
         received_r  <= '0;
         in_flight_r <= '0;
         alive_r     <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         alive_r     <= 1'b1;
         busy_r      <= busy_s;
         done_r      <= done_s;
         in_flight_r <= in_flight_r + CW'(bus_hs_s) - CW'(rsp_s);
         if (cmd_hs_s) begin
            base_r     <= {cmd_addr_i[31:2], 2'b00};
            len_r      <= cmd_len_i;
            we_r       <= cmd_we_i;
            issued_r   <= '0;
            received_r <= '0;
         end else begin
            if (bus_hs_s) issued_r   <= issued_r + LEN_WIDTH'(1);
            if (rsp_s)    received_r <= received_inc_s;
         end
      end
   end

   tcdm_init_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push_s),
      .wdata_i (tcdm_master.r_rdata),
      .pop_i   (rdata_ready_i),
      .rdata_o (rdata_o),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .count_o (fifo_count_s)
   );

   tcdm_init_chk u_chk (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .push_i           (push_s),
      .full_i           (fifo_full_s),
      .r_valid_i        (tcdm_master.r_valid),
      .in_flight_zero_i (in_flight_r == '0)
   );

   assign tcdm_master.req   = req_s;
   assign tcdm_master.add   = add_s;
   assign tcdm_master.wen   = wen_s;
   assign tcdm_master.wdata = wdata_s;
   assign tcdm_master.be    = be_s;
   assign wdata_ready_o     = wdata_rdy_s;
   assign rdata_valid_o     = ~fifo_empty_s;
   assign busy_o            = busy_r;
   assign done_o            = done_r;

endmodule

// File: tb/tb_tcdm_block_initiator.sv
// Randomized bench: a TCDM slave with memory, a write-data source and a read
// sink, checked cycle by cycle against a transaction-count reference model.
module tb_tcdm_block_initiator;
   localparam int unsigned LW = 16;
   localparam int unsigned FD = 4;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          cmd_valid_i, cmd_we_i, cmd_ready_o;
   logic [31:0]   cmd_addr_i;
   logic [LW-1:0] cmd_len_i;
   logic          wdata_valid_i, wdata_ready_o;
   logic [31:0]   wdata_i;
   logic          rdata_valid_o, rdata_ready_i;
   logic [31:0]   rdata_o;
   logic          busy_o, done_o;

   XBAR_TCDM_BUS bus();

   tcdm_block_initiator #(.LEN_WIDTH(LW), .FIFO_DEPTH(FD)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
      .cmd_len_i(cmd_len_i), .cmd_we_i(cmd_we_i),
      .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
      .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i), .rdata_o(rdata_o),
      .busy_o(busy_o), .done_o(done_o), .tcdm_master(bus)
   );

   always #5 clk_i = ~clk_i;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // reference memory of the slave; unwritten words read as a fixed pattern
   logic [31:0] mem [logic [31:0]];
   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : (a ^ 32'h5EED_0000);
   endfunction

   // reference model of the current command
   bit          act = 1'b0, mdl_we = 1'b0;
   logic [31:0] mdl_base = 32'h0;
   int unsigned mdl_len = 0, hs_cnt = 0, rsp_cmd = 0, widx = 0, shown_idx = 0;
   int unsigned rd_hs_tot = 0, rd_rsp_tot = 0, pop_tot = 0, cyc = 0, last_rsp_cyc = 0, last_due = 0;
   logic [31:0] wq[$];
   logic [31:0] exp_rd[$];
   int unsigned pend_due[$];
   logic [31:0] pend_dat[$];
   int          gnt_mode = 0;
   int unsigned lat_max = 1;
   bit          ready_rand = 1'b0, wv_rand = 1'b0, hold_ready = 1'b0, tog = 1'b1;
   bit          prev_stall = 1'b0, exp_req;
   logic [31:0] prev_add, prev_wdata, m_addr, m_data;
   int unsigned m_due;

   // monitor and slave: everything sampled mid-cycle
   initial forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
         pend_due.delete(); pend_dat.delete(); exp_rd.delete();
         hs_cnt = 0; rsp_cmd = 0; rd_hs_tot = 0; rd_rsp_tot = 0; pop_tot = 0; widx = 0;
         prev_stall = 1'b0;
      end else begin
         exp_req = act && (hs_cnt < mdl_len) &&
                   (mdl_we ? wdata_valid_i : ((rd_hs_tot - pop_tot) < FD));
         check("req", bus.req, exp_req);
         check("wdata_ready", wdata_ready_o, exp_req & bus.gnt & mdl_we);
         check("rdata_valid", rdata_valid_o, rd_rsp_tot != pop_tot);
         if (prev_stall) begin
            check("stall_add", bus.add, prev_add);
            check("stall_wdata", bus.wdata, prev_wdata);
         end
         if (bus.req && bus.gnt) begin
            m_addr = mdl_base + (hs_cnt << 2);
            check("add", bus.add, m_addr);
            check("be", bus.be, 4'hF);
            check("wen", bus.wen, !mdl_we);
            if (mdl_we) begin
               check("wdata", bus.wdata, wq[hs_cnt]);
               mem[bus.add] = bus.wdata;
               m_data = 32'h0;
            end else begin
               m_data = mem_rd(bus.add);
               rd_hs_tot++;
            end
            m_due = cyc + $urandom_range(1, lat_max);
            if (m_due <= last_due) m_due = last_due + 1;
            last_due = m_due;
            pend_due.push_back(m_due);
            pend_dat.push_back(m_data);
            hs_cnt++;
         end
         prev_stall = bus.req && !bus.gnt;
         prev_add   = bus.add;
         prev_wdata = bus.wdata;
         if (bus.r_valid) begin
            rsp_cmd++;
            last_rsp_cyc = cyc;
            if (!mdl_we) rd_rsp_tot++;
         end
         if (rdata_valid_o && rdata_ready_i) begin
            if (exp_rd.size() != 0) check("rdata", rdata_o, exp_rd.pop_front());
            pop_tot++;
         end
         if (wdata_valid_i && wdata_ready_o) widx++;
      end
   end

   // input driver: gnt, responses, read-ready and write data, 1 after the edge
   initial begin
      bus.gnt = 1'b0; bus.r_valid = 1'b0; bus.r_rdata = 32'h0; bus.r_opc = 1'b0;
      rdata_ready_i = 1'b0; wdata_valid_i = 1'b0; wdata_i = 32'h0;
      forever begin
         @(posedge clk_i); #1;
         cyc++;
         case (gnt_mode)
            0:       bus.gnt = 1'b1;
            1:       begin bus.gnt = tog; tog = !tog; end
            default: bus.gnt = 1'($urandom_range(0, 1));
         endcase
         if (rst_ni && pend_due.size() != 0 && pend_due[0] <= cyc) begin
            bus.r_valid = 1'b1;
            bus.r_rdata = pend_dat.pop_front();
            void'(pend_due.pop_front());
         end else begin
            bus.r_valid = 1'b0;
            bus.r_rdata = 32'h0;
         end
         rdata_ready_i = hold_ready ? 1'b0 : (ready_rand ? 1'($urandom_range(0, 1)) : 1'b1);
         if (rst_ni && act && mdl_we && widx < wq.size()) begin
            if (!(wdata_valid_i && shown_idx == widx)) begin
               wdata_valid_i = wv_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
               wdata_i       = wq[widx];
               shown_idx     = widx;
            end
         end else begin
            wdata_valid_i = 1'b0;
         end
      end
   end

   task automatic check_reset_outputs();
      check("rst_req", bus.req, 1'b0);
      check("rst_add", bus.add, 32'h0);
      check("rst_wen", bus.wen, 1'b1);
      check("rst_wdata", bus.wdata, 32'h0);
      check("rst_be", bus.be, 4'h0);
      check("rst_cmd_ready", cmd_ready_o, 1'b0);
      check("rst_wdata_ready", wdata_ready_o, 1'b0);
      check("rst_rdata_valid", rdata_valid_o, 1'b0);
      check("rst_rdata", rdata_o, 32'h0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_done", done_o, 1'b0);
   endtask

   task automatic start_cmd(input logic [31:0] addr, input int unsigned len, input bit we,
                            input int gm, input int unsigned lm, input bit rr, input bit wr, input bit hold);
      gnt_mode = gm; lat_max = lm; ready_rand = rr; wv_rand = wr; tog = 1'b1;
      mdl_base = {addr[31:2], 2'b00}; mdl_len = len; mdl_we = we;
      hs_cnt = 0; rsp_cmd = 0; widx = 0; wq.delete();
      for (int i = 0; i < int'(len); i++) begin
         if (we) wq.push_back($urandom());
         else    exp_rd.push_back(mem_rd(mdl_base + 32'(i) * 32'd4));
      end
      hold_ready = hold;
      @(posedge clk_i); #2;
      cmd_valid_i = 1'b1; cmd_addr_i = addr; cmd_len_i = LW'(len); cmd_we_i = we;
      @(negedge clk_i); #1;
      check("cmd_ready", cmd_ready_o, 1'b1);
      @(posedge clk_i); #2;
      cmd_valid_i = 1'b0;
      act = 1'b1;
   endtask

   task automatic finish_cmd(input int unsigned hold_cycles);
      int unsigned waited = 0;
      bit          seen = 1'b0;
      if (mdl_len == 0) begin
         @(negedge clk_i); #1;
         check("done_len0", done_o, 1'b1);
         check("busy_len0", busy_o, 1'b0);
      end else begin
         while (!seen && waited < 600) begin
            @(negedge clk_i); #1;
            waited++;
            if (hold_cycles != 0 && waited == hold_cycles) begin
               check("stall_grants", hs_cnt, FD);
               check("stall_req", bus.req, 1'b0);
               hold_ready = 1'b0;
            end
            check("busy", busy_o, 1'b1);
            seen = done_o;
         end
         check("done_seen", seen, 1'b1);
         check("rsp_count", rsp_cmd, mdl_len);
         check("done_latency", cyc, last_rsp_cyc + 1);
      end
      @(negedge clk_i); #1;
      check("done_pulse", done_o, 1'b0);
      check("busy_after", busy_o, 1'b0);
      check("cmd_ready_after", cmd_ready_o, 1'b1);
      hold_ready = 1'b0;
      waited = 0;
      while (exp_rd.size() != 0 && waited < 300) begin
         @(negedge clk_i); #1;
         waited++;
      end
      check("rd_drained", exp_rd.size(), 0);
      if (mdl_we) begin
         for (int i = 0; i < int'(mdl_len); i++) check("mem", mem_rd(mdl_base + 32'(i) * 32'd4), wq[i]);
      end
      act = 1'b0;
   endtask

   task automatic run_cmd(input logic [31:0] addr, input int unsigned len, input bit we, input int gm,
                          input int unsigned lm, input bit rr, input bit wr, input int unsigned hold_cycles);
      start_cmd(addr, len, we, gm, lm, rr, wr, hold_cycles != 0);
      finish_cmd(hold_cycles);
   endtask

   initial begin
      int unsigned waited;
      rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = 32'h0; cmd_len_i = '0;
      #3;
      check_reset_outputs();
      repeat (3) @(posedge clk_i);
      #2 rst_ni = 1'b1;
      repeat (2) @(posedge clk_i);

      run_cmd(32'h0000_0100, 4, 1'b0, 0, 1, 1'b0, 1'b0, 0);   // basic read burst
      run_cmd(32'h0000_0400, 8, 1'b0, 0, 1, 1'b0, 1'b0, 20);  // sink stalled: credit limit
      run_cmd(32'h0000_0200, 3, 1'b1, 1, 1, 1'b0, 1'b0, 0);   // write, gnt toggling
      run_cmd(32'h0000_0200, 3, 1'b0, 0, 1, 1'b0, 1'b0, 0);   // read the written words back
      run_cmd(32'h0000_0500, 0, 1'b0, 0, 1, 1'b0, 1'b0, 0);   // zero-length command
      run_cmd(32'hFFFF_FFF8, 4, 1'b0, 0, 1, 1'b0, 1'b0, 0);   // address wrap

      // reset in the middle of a 6-word read, after 2 grants
      start_cmd(32'h0000_0300, 6, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0);
      waited = 0;
      while (hs_cnt < 2 && waited < 50) begin
         @(negedge clk_i); #1;
         waited++;
      end
      check("pre_reset_grants", hs_cnt, 2);
      rst_ni = 1'b0;
      act = 1'b0;
      #1;
      check_reset_outputs();
      exp_rd.delete();
      repeat (2) @(posedge clk_i);
      #2 rst_ni = 1'b1;
      repeat (2) @(posedge clk_i);
      run_cmd(32'h0000_0600, 2, 1'b0, 0, 1, 1'b0, 1'b0, 0);

      // randomized commands: direction, length, alignment, grant and latency patterns
      for (int k = 0; k < 14; k++) begin
         logic [31:0] a;
         a = (k % 4 == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : ($urandom() & 32'h0000_0FFF);
         run_cmd(a, $urandom_range(0, 10), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                 $urandom_range(1, 3), 1'b1, 1'b1, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
